// File: rtl/preamble_sequencer.sv
// Legacy 802.11 preamble sequencer: launches STF then LTF generators, merges their samples
// into one registered stream, owns the LTF coefficient register. Optional: PREAMBLE_SEQ_WATCHDOG_EN.
module preamble_sequencer #(
  parameter int SAMPLE_W = 32,
  parameter int STF_LEN  = 160,
  parameter int LTF_LEN  = 160
`ifdef PREAMBLE_SEQ_WATCHDOG_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                tx_start,
  input  logic                abort,
  input  logic                coeff_load,
  input  logic [127:0]        coeff_in,
  output logic                stf_letsgo,
  input  logic                stf_started,
  input  logic [SAMPLE_W-1:0] stf_sample,
  output logic                ltf_letsgo,
  input  logic                ltf_started,
  input  logic [SAMPLE_W-1:0] ltf_sample,
  output logic [127:0]        ltf_coeff,
  output logic [SAMPLE_W-1:0] out_sample,
  output logic                out_valid,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [7:0] STF_LAST = 8'(STF_LEN - 1);
  localparam logic [7:0] LTF_LAST = 8'(LTF_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STF_ARM, S_STF_RUN, S_LTF_ARM, S_LTF_RUN, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q;
  logic                active_q;     // generator has produced sample #0 in this RUN state
  logic                in_run, started_sel, fwd, wd_expire, run_next;
  logic [7:0]          cnt_last;
  logic [SAMPLE_W-1:0] sample_sel;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    stf_letsgo  = 1'b0;
    ltf_letsgo  = 1'b0;
    in_run      = 1'b0;
    started_sel = stf_started;
    sample_sel  = stf_sample;
    cnt_last    = STF_LAST;
    case (state_q)
      S_STF_ARM: stf_letsgo = 1'b1;
      S_LTF_ARM: ltf_letsgo = 1'b1;
      S_STF_RUN: in_run = 1'b1;
      S_LTF_RUN: begin
        in_run      = 1'b1;
        started_sel = ltf_started;
        sample_sel  = ltf_sample;
        cnt_last    = LTF_LAST;
      end
      default: ;
    endcase

    fwd = in_run && (active_q || started_sel);

    state_d = state_q;
    case (state_q)
      S_IDLE:    if (tx_start) state_d = S_STF_ARM;
      S_STF_ARM: state_d = S_STF_RUN;
      S_STF_RUN: if (fwd && cnt_q == cnt_last) state_d = S_LTF_ARM;
      S_LTF_ARM: state_d = S_LTF_RUN;
      S_LTF_RUN: if (fwd && cnt_q == cnt_last) state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
    if (wd_expire || abort) state_d = S_IDLE;
  end

  assign busy     = (state_q != S_IDLE);
  assign run_next = (state_d == S_STF_RUN) || (state_d == S_LTF_RUN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the coefficient register is reset like any other state; the generator must
    // never see X coefficients even if no load ever happens.
    if (!rstn) begin
      cnt_q      <= '0;
      active_q   <= 1'b0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      ltf_coeff  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid <= fwd && !abort;
      if (fwd) out_sample <= sample_sel;
      done <= (state_q == S_DONE) && !abort;
      if (state_q == S_IDLE && coeff_load) ltf_coeff <= coeff_in;
      // Counters only live inside a RUN state; any other next state clears them.
      if (!run_next) begin
        cnt_q    <= '0;
        active_q <= 1'b0;
      end else if (fwd) begin
        cnt_q    <= cnt_q + 8'd1;
        active_q <= 1'b1;
      end
    end
  end

`ifdef PREAMBLE_SEQ_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wd_q;

  assign wd_expire = in_run && !fwd && (wd_q == WD_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_q <= '0;
      err  <= 1'b0;
    end else begin
      err <= wd_expire && !abort;
      if (in_run && !fwd && !wd_expire && !abort) wd_q <= wd_q + 8'd1;
      else                                        wd_q <= '0;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

endmodule
